change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Sequential, parametrised successor to the two-coin combinational change machine. Accepts one transaction (cost, paid) via a valid/ready handshake and tracks its own coin inventory. Dispenses change greedily, one coin per accepted beat on a coin stream, up to MAX_COINS coins, then reports a status. Sits between the payment front-end and the coin-eject actuator. All amounts are in nickel units: quarter = 5, dime = 2, nickel = 1.

Parameters:
AMT_W, 8, width of cost, paid and remaining (nickel units)
CNT_W, 4, width of each per-denomination inventory counter
MAX_COINS, 4, maximum coins dispensed per transaction (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  transaction request
start_ready  out  1  high only in IDLE
cost  in  AMT_W  price, sampled on start handshake
paid  in  AMT_W  amount paid, sampled on start handshake
restock_valid  in  1  add coins to inventory
restock_ready  out  1  high only in IDLE
restock_q  in  CNT_W  quarters to add
restock_d  in  CNT_W  dimes to add
restock_n  in  CNT_W  nickels to add
coin_valid  out  1  coin offered
coin_ready  in  1  actuator accepts coin
coin  out  2  coin_e code of offered coin
done  out  1  one-cycle pulse at end of transaction
status  out  2  status_e, held until next start
remaining  out  AMT_W  undelivered change or shortfall, held until next start
inv_q  out  CNT_W  quarter inventory
inv_d  out  CNT_W  dime inventory
inv_n  out  CNT_W  nickel inventory

Behaviour:
- Reset (async assert, sync release): state IDLE; inventory 0; remaining 0; status EXACT; done, coin_valid 0; coin NONE; coin count 0.
- FSM states: IDLE, CALC, DISPENSE, DONE.
- IDLE: start_ready = restock_ready = 1.
  - Restock handshake: each counter += its addend, saturating at 2^CNT_W-1.
  - Start handshake: register cost and paid; go to CALC.
  - Both in the same cycle: both accepted; CALC sees the restocked inventory.
- CALC (1 cycle):
  - paid < cost: remaining = cost-paid, status UNDERPAID, go to DONE.
  - paid == cost: remaining = 0, status EXACT, go to DONE.
  - Otherwise: remaining = paid-cost, coin count = 0, go to DISPENSE.
- DISPENSE: greedy selection from the registered remaining and inventory, priority QUARTER, DIME, NICKEL. A coin is eligible if its value <= remaining and its count > 0. Comparisons are <=, not <.
  - Eligible coin exists and coin count < MAX_COINS: coin_valid = 1, coin = selected code.
  - On coin_valid & coin_ready: that inventory counter -1, remaining -= coin value, coin count +1.
  - coin and coin_valid stay stable while coin_ready is low; inventory cannot change in this state.
  - remaining == 0: go to DONE, status CHANGE_OK.
  - remaining > 0 and either no eligible coin or coin count == MAX_COINS: go to DONE, status CHANGE_SHORT. coin_valid stays 0 in that cycle.
- DONE: done = 1 for exactly one cycle; status and remaining are valid; next state IDLE.
- Latency: EXACT and UNDERPAID raise done 2 cycles after the start handshake. Dispensing adds at least 1 cycle per coin.
- Reset mid-transaction aborts it: no done pulse, inventory cleared.
- Inputs at unused times: start_valid and restock_valid outside IDLE are ignored (not accepted); coin_ready outside DISPENSE is ignored.

Decomposition:
- Package change_pkg:
  - coin_e (NONE=0, NICKEL=1, DIME=2, QUARTER=3)
  - status_e (EXACT, CHANGE_OK, CHANGE_SHORT, UNDERPAID)
  - state_e
  - constants Q_VAL=5, D_VAL=2, N_VAL=1
  - function coin_value(coin_e)
- One sub-module: coin_select, purely combinational. Takes remaining and the three counts; outputs coin_e (NONE if nothing is eligible). It is instantiated once at module level, not inside always blocks.

Test Plan:
- Restock q=2,d=2,n=2; cost=3, paid=10, coin_ready=1 -> coins QUARTER then DIME; done; CHANGE_OK; remaining=0; inv q=1,d=1,n=2.
- cost=9, paid=4 -> no coin_valid; done 2 cycles after start; UNDERPAID; remaining=5. cost=paid=6 -> EXACT, remaining=0.
- Inventory q=0,d=1,n=1; cost=0, paid=7 -> DIME, NICKEL; CHANGE_SHORT; remaining=4; inventory all 0.
- Nickels only (n=15), MAX_COINS=4; cost=0, paid=20 -> exactly 4 NICKELs; CHANGE_SHORT; remaining=16; inv_n=11.
- Backpressure: coin_ready held low 3 cycles during DISPENSE -> coin and coin_valid stable, inventory unchanged. Restock n=15 on inv_n=10 -> saturates at 15. start_valid and restock_valid asserted together in IDLE -> both accepted.
- Assert rst_n low mid-DISPENSE -> outputs immediately at reset values, no done pulse. After release, start_ready=1 in IDLE.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: coin codes, status codes,
// FSM states and the nickel-unit value of each coin.
package change_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        NICKEL  = 2'd1,
        DIME    = 2'd2,
        QUARTER = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        EXACT        = 2'd0,
        CHANGE_OK    = 2'd1,
        CHANGE_SHORT = 2'd2,
        UNDERPAID    = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC     = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [2:0] Q_VAL = 3'd5;
    localparam logic [2:0] D_VAL = 3'd2;
    localparam logic [2:0] N_VAL = 3'd1;

    function automatic logic [2:0] coin_value(input coin_e c);
        case (c)
            QUARTER: coin_value = Q_VAL;
            DIME:    coin_value = D_VAL;
            NICKEL:  coin_value = N_VAL;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the start, restock, coin-stream and result signals of the dispenser.
// The master side is the payment front-end / actuator environment.
interface change_dispenser_if
    import change_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int CNT_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [AMT_W-1:0] cost;
    logic [AMT_W-1:0] paid;
    logic             restock_valid;
    logic             restock_ready;
    logic [CNT_W-1:0] restock_q;
    logic [CNT_W-1:0] restock_d;
    logic [CNT_W-1:0] restock_n;
    logic             coin_valid;
    logic             coin_ready;
    coin_e            coin;
    logic             done;
    status_e          status;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] inv_q;
    logic [CNT_W-1:0] inv_d;
    logic [CNT_W-1:0] inv_n;

    modport master (
        output start_valid, cost, paid,
        output restock_valid, restock_q, restock_d, restock_n,
        output coin_ready,
        input  start_ready, restock_ready, coin_valid, coin,
        input  done, status, remaining, inv_q, inv_d, inv_n
    );

    modport slave (
        input  start_valid, cost, paid,
        input  restock_valid, restock_q, restock_d, restock_n,
        input  coin_ready,
        output start_ready, restock_ready, coin_valid, coin,
        output done, status, remaining, inv_q, inv_d, inv_n
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin whose value fits in the remaining change and
// which is still in stock; NONE when nothing qualifies.
module change_dispenser_coin_select
    import change_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [CNT_W-1:0] cnt_q,
    input  logic [CNT_W-1:0] cnt_d,
    input  logic [CNT_W-1:0] cnt_n,
    output coin_e            sel
);

    // Priority QUARTER > DIME > NICKEL, value may equal the remaining amount
    always_comb begin
        sel = NONE;
        if ((cnt_q != '0) && (AMT_W'(Q_VAL) <= remaining)) begin
            sel = QUARTER;
        end else if ((cnt_d != '0) && (AMT_W'(D_VAL) <= remaining)) begin
            sel = DIME;
        end else if ((cnt_n != '0) && (AMT_W'(N_VAL) <= remaining)) begin
            sel = NICKEL;
        end else begin
            sel = NONE;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Sequential change dispenser: accepts a (cost, paid) transaction, keeps its own
// coin inventory and streams greedy change one coin per accepted beat.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W     = 8,
    parameter int CNT_W     = 4,
    parameter int MAX_COINS = 4
) (
    input logic         clk,
    input logic         rst_n,
    change_dispenser_if.slave bus
);

    localparam int CC_W = (MAX_COINS < 2) ? 1 : $clog2(MAX_COINS + 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [AMT_W-1:0] cost_r;
    logic [AMT_W-1:0] paid_r;
    logic [AMT_W-1:0] remaining_r;
    status_e          status_r;
    logic             done_r;
    logic [CNT_W-1:0] inv_q_r;
    logic [CNT_W-1:0] inv_d_r;
    logic [CNT_W-1:0] inv_n_r;
    logic [CC_W-1:0]  coin_cnt_r;

    coin_e            sel_s;
    coin_e            coin_s;
    logic             coin_valid_s;
    logic             idle_s;
    logic             start_fire_s;
    logic             restock_fire_s;
    logic             coin_fire_s;
    logic [AMT_W-1:0] coin_amt_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    change_dispenser_coin_select #(
        .AMT_W (AMT_W),
        .CNT_W (CNT_W)
    ) u_coin_select (
        .remaining (remaining_r),
        .cnt_q     (inv_q_r),
        .cnt_d     (inv_d_r),
        .cnt_n     (inv_n_r),
        .sel       (sel_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM outputs and handshake qualifiers, all derived from registered state
    always_comb begin
        idle_s       = (state_r == IDLE);
        coin_valid_s = 1'b0;
        coin_s       = NONE;
        if ((state_r == DISPENSE) && (sel_s != NONE) &&
            (coin_cnt_r < CC_W'(MAX_COINS))) begin
            coin_valid_s = 1'b1;
            coin_s       = sel_s;
        end else begin
            coin_valid_s = 1'b0;
            coin_s       = NONE;
        end
        start_fire_s   = idle_s & bus.start_valid;
        restock_fire_s = idle_s & bus.restock_valid;
        coin_fire_s    = coin_valid_s & bus.coin_ready;
        coin_amt_s     = AMT_W'(coin_value(coin_s));
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:     state_nxt_s = start_fire_s ? CALC : IDLE;
            CALC:     state_nxt_s = (paid_r > cost_r) ? DISPENSE : DONE;
            // Leaving covers both "all change given" and "cannot give more"
            DISPENSE: state_nxt_s = coin_valid_s ? DISPENSE : DONE;
            DONE:     state_nxt_s = IDLE;
            default:  state_nxt_s = IDLE;
        endcase
    end

    // Transaction datapath, inventory and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cost_r      <= '0;
            paid_r      <= '0;
            remaining_r <= '0;
            status_r    <= EXACT;
            done_r      <= 1'b0;
            inv_q_r     <= '0;
            inv_d_r     <= '0;
            inv_n_r     <= '0;
            coin_cnt_r  <= '0;
        end else begin
            done_r <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_fire_s) begin
                        cost_r <= bus.cost;
                        paid_r <= bus.paid;
                    end
                    if (restock_fire_s) begin
                        inv_q_r <= sat_add(inv_q_r, bus.restock_q);
                        inv_d_r <= sat_add(inv_d_r, bus.restock_d);
                        inv_n_r <= sat_add(inv_n_r, bus.restock_n);
                    end
                end
                CALC: begin
                    coin_cnt_r <= '0;
                    if (paid_r < cost_r) begin
                        remaining_r <= cost_r - paid_r;
                        status_r    <= UNDERPAID;
                    end else if (paid_r == cost_r) begin
                        remaining_r <= '0;
                        status_r    <= EXACT;
                    end else begin
                        remaining_r <= paid_r - cost_r;
                    end
                end
                DISPENSE: begin
                    if (coin_fire_s) begin
                        remaining_r <= remaining_r - coin_amt_s;
                        coin_cnt_r  <= coin_cnt_r + CC_W'(1'b1);
                        case (coin_s)
                            QUARTER: inv_q_r <= inv_q_r - CNT_W'(1'b1);
                            DIME:    inv_d_r <= inv_d_r - CNT_W'(1'b1);
                            NICKEL:  inv_n_r <= inv_n_r - CNT_W'(1'b1);
                            default: inv_n_r <= inv_n_r;
                        endcase
                    end else if (!coin_valid_s) begin
                        status_r <= (remaining_r == '0) ? CHANGE_OK : CHANGE_SHORT;
                    end
                end
                default: begin
                    coin_cnt_r <= coin_cnt_r;
                end
            endcase
        end
    end

    assign bus.start_ready   = idle_s;
    assign bus.restock_ready = idle_s;
    assign bus.coin_valid    = coin_valid_s;
    assign bus.coin          = coin_s;
    assign bus.done          = done_r;
    assign bus.status        = status_r;
    assign bus.remaining     = remaining_r;
    assign bus.inv_q         = inv_q_r;
    assign bus.inv_d         = inv_d_r;
    assign bus.inv_n         = inv_n_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (AMT_W=8, CNT_W=4, MAX_COINS=4).
module tb_change_dispenser;
    import change_pkg::*;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;

    coin_e got_coins [0:7];
    int    got_n;
    int    got_lat;
    bit    got_to;
    logic  got_done_after;

    change_dispenser_if #(.AMT_W(8), .CNT_W(4)) bus ();

    change_dispenser #(.AMT_W(8), .CNT_W(4), .MAX_COINS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus: one start handshake (optionally with a simultaneous restock), then
    // collect accepted coins until done or the cycle budget expires.
    task automatic run_txn(input logic [7:0] c, input logic [7:0] p, input bit rv,
                           input logic [3:0] rq, input logic [3:0] rd, input logic [3:0] rn);
        got_n = 0; got_lat = 0; got_to = 1'b1;
        bus.cost = c; bus.paid = p; bus.start_valid = 1'b1;
        bus.restock_valid = rv; bus.restock_q = rq; bus.restock_d = rd; bus.restock_n = rn;
        tick();
        bus.start_valid = 1'b0; bus.restock_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.done) begin
                got_lat = cyc; got_to = 1'b0;
                break;
            end
            if (bus.coin_valid && bus.coin_ready) begin
                if (got_n < 8) got_coins[got_n] = bus.coin;
                got_n++;
            end
            tick();
        end
        tick();
        got_done_after = bus.done;
    endtask

    task automatic do_restock(input logic [3:0] q, input logic [3:0] d, input logic [3:0] n);
        bus.restock_q = q; bus.restock_d = d; bus.restock_n = n; bus.restock_valid = 1'b1;
        tick();
        bus.restock_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.coin_valid !== 1'b0) begin n_fail++; $display("FAIL reset_coin_valid got %0b want 0", bus.coin_valid); end
        n_checks++; if (bus.coin !== NONE) begin n_fail++; $display("FAIL reset_coin got %0d want 0", bus.coin); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.start_ready !== 1'b1 || bus.restock_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b%0b want 11", bus.start_ready, bus.restock_ready); end
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h000) begin n_fail++; $display("FAIL reset_inv got %h want 000", {bus.inv_q, bus.inv_d, bus.inv_n}); end
        n_checks++; if (bus.status !== EXACT || bus.remaining !== 8'd0) begin n_fail++; $display("FAIL reset_result got st=%0d rem=%0d want st=0 rem=0", bus.status, bus.remaining); end
    endtask

    task automatic test_change_ok();
        do_restock(4'd2, 4'd2, 4'd2);
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h222) begin n_fail++; $display("FAIL restock_inv got %h want 222", {bus.inv_q, bus.inv_d, bus.inv_n}); end
        run_txn(8'd3, 8'd10, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++; if (got_to !== 1'b0) begin n_fail++; $display("FAIL ok_timeout got %0b want 0", got_to); end
        n_checks++; if (got_n !== 2 || got_coins[0] !== QUARTER || got_coins[1] !== DIME) begin n_fail++; $display("FAIL ok_coins got n=%0d c0=%0d c1=%0d want n=2 c0=3 c1=2", got_n, got_coins[0], got_coins[1]); end
        n_checks++; if (bus.status !== CHANGE_OK || bus.remaining !== 8'd0) begin n_fail++; $display("FAIL ok_result got st=%0d rem=%0d want st=1 rem=0", bus.status, bus.remaining); end
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h112) begin n_fail++; $display("FAIL ok_inv got %h want 112", {bus.inv_q, bus.inv_d, bus.inv_n}); end
    endtask

    task automatic test_underpaid_exact();
        run_txn(8'd9, 8'd4, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++; if (got_lat !== 2 || got_n !== 0) begin n_fail++; $display("FAIL under_latency got lat=%0d coins=%0d want lat=2 coins=0", got_lat, got_n); end
        n_checks++; if (bus.status !== UNDERPAID || bus.remaining !== 8'd5) begin n_fail++; $display("FAIL under_result got st=%0d rem=%0d want st=3 rem=5", bus.status, bus.remaining); end
        n_checks++; if (got_done_after !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %0b want 0", got_done_after); end
        run_txn(8'd6, 8'd6, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++; if (got_lat !== 2 || got_n !== 0) begin n_fail++; $display("FAIL exact_latency got lat=%0d coins=%0d want lat=2 coins=0", got_lat, got_n); end
        n_checks++; if (bus.status !== EXACT || bus.remaining !== 8'd0) begin n_fail++; $display("FAIL exact_result got st=%0d rem=%0d want st=0 rem=0", bus.status, bus.remaining); end
    endtask

    task automatic test_change_short();
        // Drain to q=0,d=1,n=1: one quarter then one nickel
        run_txn(8'd0, 8'd5, 1'b0, 4'd0, 4'd0, 4'd0);
        run_txn(8'd0, 8'd1, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h011) begin n_fail++; $display("FAIL drain_inv got %h want 011", {bus.inv_q, bus.inv_d, bus.inv_n}); end
        run_txn(8'd0, 8'd7, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++; if (got_n !== 2 || got_coins[0] !== DIME || got_coins[1] !== NICKEL) begin n_fail++; $display("FAIL short_coins got n=%0d c0=%0d c1=%0d want n=2 c0=2 c1=1", got_n, got_coins[0], got_coins[1]); end
        n_checks++; if (bus.status !== CHANGE_SHORT || bus.remaining !== 8'd4) begin n_fail++; $display("FAIL short_result got st=%0d rem=%0d want st=2 rem=4", bus.status, bus.remaining); end
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h000) begin n_fail++; $display("FAIL short_inv got %h want 000", {bus.inv_q, bus.inv_d, bus.inv_n}); end
    endtask

    task automatic test_max_coins();
        do_restock(4'd0, 4'd0, 4'd15);
        run_txn(8'd0, 8'd20, 1'b0, 4'd0, 4'd0, 4'd0);
        n_checks++; if (got_n !== 4 || got_coins[0] !== NICKEL || got_coins[3] !== NICKEL) begin n_fail++; $display("FAIL max_coins got n=%0d c0=%0d c3=%0d want n=4 c0=1 c3=1", got_n, got_coins[0], got_coins[3]); end
        n_checks++; if (bus.status !== CHANGE_SHORT || bus.remaining !== 8'd16) begin n_fail++; $display("FAIL max_result got st=%0d rem=%0d want st=2 rem=16", bus.status, bus.remaining); end
        n_checks++; if (bus.inv_n !== 4'd11) begin n_fail++; $display("FAIL max_inv_n got %0d want 11", bus.inv_n); end
    endtask

    task automatic test_backpressure();
        bit seen;
        bus.coin_ready = 1'b0;
        bus.cost = 8'd0; bus.paid = 8'd1; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (bus.coin_valid) seen = 1'b1; else tick();
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_coin_timeout got %0b want 1", seen); end
        // Hold off the actuator while also trying to start and restock
        bus.start_valid = 1'b1; bus.restock_valid = 1'b1;
        bus.restock_q = 4'd1; bus.restock_d = 4'd1; bus.restock_n = 4'd1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.coin_valid !== 1'b1 || bus.coin !== NICKEL) begin n_fail++; $display("FAIL bp_stable cyc=%0d got v=%0b c=%0d want v=1 c=1", i, bus.coin_valid, bus.coin); end
            n_checks++; if (bus.start_ready !== 1'b0 || bus.restock_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc=%0d got %0b%0b want 00", i, bus.start_ready, bus.restock_ready); end
            tick();
            n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h00b) begin n_fail++; $display("FAIL bp_inv cyc=%0d got %h want 00b", i, {bus.inv_q, bus.inv_d, bus.inv_n}); end
        end
        bus.start_valid = 1'b0; bus.restock_valid = 1'b0;
        bus.coin_ready = 1'b1;
        tick();
        n_checks++; if (bus.inv_n !== 4'd10 || bus.remaining !== 8'd0) begin n_fail++; $display("FAIL bp_accept got n=%0d rem=%0d want n=10 rem=0", bus.inv_n, bus.remaining); end
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (bus.done) seen = 1'b1; else tick();
        end
        n_checks++; if (seen !== 1'b1 || bus.status !== CHANGE_OK) begin n_fail++; $display("FAIL bp_done got done=%0b st=%0d want done=1 st=1", seen, bus.status); end
        tick();
        do_restock(4'd0, 4'd0, 4'd15);
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h00f) begin n_fail++; $display("FAIL sat_inv got %h want 00f", {bus.inv_q, bus.inv_d, bus.inv_n}); end
    endtask

    task automatic test_back_to_back();
        n_checks++; if (bus.start_ready !== 1'b1 || bus.restock_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %0b%0b want 11", bus.start_ready, bus.restock_ready); end
        run_txn(8'd0, 8'd5, 1'b1, 4'd1, 4'd0, 4'd0);
        n_checks++; if (got_n !== 1 || got_coins[0] !== QUARTER) begin n_fail++; $display("FAIL b2b_coins got n=%0d c0=%0d want n=1 c0=3", got_n, got_coins[0]); end
        n_checks++; if (bus.status !== CHANGE_OK || {bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h00f) begin n_fail++; $display("FAIL b2b_result got st=%0d inv=%h want st=1 inv=00f", bus.status, {bus.inv_q, bus.inv_d, bus.inv_n}); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.coin_ready = 1'b0;
        bus.cost = 8'd0; bus.paid = 8'd3; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (bus.coin_valid) seen = 1'b1; else tick();
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_coin_timeout got %0b want 1", seen); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.coin_valid !== 1'b0 || bus.coin !== NONE || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs got v=%0b c=%0d d=%0b want 0 0 0", bus.coin_valid, bus.coin, bus.done); end
        n_checks++; if ({bus.inv_q, bus.inv_d, bus.inv_n} !== 12'h000 || bus.remaining !== 8'd0) begin n_fail++; $display("FAIL rst_mid_state got inv=%h rem=%0d want 000 0", {bus.inv_q, bus.inv_d, bus.inv_n}, bus.remaining); end
        bus.coin_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done got %0b want 0", seen); end
        n_checks++; if (bus.start_ready !== 1'b1 || bus.status !== EXACT) begin n_fail++; $display("FAIL rst_mid_idle got rdy=%0b st=%0d want 1 0", bus.start_ready, bus.status); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.start_valid = 1'b0; bus.cost = 8'd0; bus.paid = 8'd0;
        bus.restock_valid = 1'b0; bus.restock_q = 4'd0; bus.restock_d = 4'd0; bus.restock_n = 4'd0;
        bus.coin_ready = 1'b1;
        test_reset();
        test_change_ok();
        test_underpaid_exact();
        test_change_short();
        test_max_coins();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
